// File: rtl/seg7_mux_driver.sv
// Multiplexed seven-segment display driver.
// Scans NUM_DIGITS digits in time slots of REFRESH_DIV clocks, with a dead time
// of BLANK_CYCLES at the start of each slot so that segments do not ghost.
// New display data is double-buffered and committed only at a frame boundary.
module seg7_mux_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 4,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter bit LZ_SUPPRESS  = 1'b0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ENABLE,
    input  logic                    LOAD_IN,
    input  logic [4*NUM_DIGITS-1:0] DIGITS_IN,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic [NUM_DIGITS-1:0]   BLANK_IN,
    output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
    output logic [7:0]              HEX_OUT,
    output logic                    FRAME_DONE_OUT
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [PW:0]   BLANK_END  = (PW + 1)'(BLANK_CYCLES);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [7:0]    HEX_OFF    = ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
    } disp_t;

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  wrap;
    logic                  lit;
    disp_t                 load_data;
    disp_t                 pend;
    disp_t                 disp;
    logic                  pend_vld;
    logic [NUM_DIGITS-1:0] lz_dark;
    logic [NUM_DIGITS-1:0] sel_hot;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  cur_lz;
    logic [7:0]            seg_on;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
        endcase
    endfunction

    assign tick      = ENABLE && (presc == PRESC_LAST);
    assign wrap      = tick && (idx == IDX_LAST);
    assign lit       = ENABLE && ({1'b0, presc} >= BLANK_END);
    assign load_data = '{digits: DIGITS_IN, dp: DP_IN, blank: BLANK_IN};

    // Slot prescaler and digit index; both frozen while scanning is disabled.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else if (ENABLE) begin
            presc <= presc + PW'(1);
        end
    end

    // End-of-frame strobe, one cycle after the wrapping tick.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) FRAME_DONE_OUT <= 1'b0;
        else       FRAME_DONE_OUT <= wrap;
    end

    // Double-buffered display data. A direct write (idle, or load landing on
    // the wrap tick) supersedes anything pending, so the flag is dropped.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend     <= '0;
            disp     <= '0;
            pend_vld <= 1'b0;
        end else if (LOAD_IN && (!ENABLE || wrap)) begin
            disp     <= load_data;
            pend_vld <= 1'b0;
        end else if (LOAD_IN) begin
            pend     <= load_data;
            pend_vld <= 1'b1;
        end else if (wrap && pend_vld) begin
            disp     <= pend;
            pend_vld <= 1'b0;
        end
    end

    // Leading-zero mask: a digit is dark if it and every digit above it are zero.
    always_comb begin
        logic upper_zero;
        lz_dark    = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (disp.digits[i*4 +: 4] == 4'h0);
            lz_dark[i] = LZ_SUPPRESS & upper_zero;
        end
    end

    // Select the current digit's data and build its active-high segment pattern.
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        sel_hot   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib    = disp.digits[i*4 +: 4];
                cur_dp     = disp.dp[i];
                cur_blank  = disp.blank[i];
                cur_lz     = lz_dark[i];
                sel_hot[i] = 1'b1;
            end
        end
        if (cur_blank)   seg_on = 8'h00;
        else if (cur_lz) seg_on = {cur_dp, 7'h00};
        else             seg_on = {cur_dp, seg7(cur_nib)};
    end

    // Registered outputs, already in pad polarity; dark during dead time and when idle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SEG_SELECT_OUT <= SEL_OFF;
            HEX_OUT        <= HEX_OFF;
        end else if (lit) begin
            SEG_SELECT_OUT <= sel_hot ^ SEL_OFF;
            HEX_OUT        <= seg_on ^ HEX_OFF;
        end else begin
            SEG_SELECT_OUT <= SEL_OFF;
            HEX_OUT        <= HEX_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver: 4 digits, 8-cycle slots, 2 dead cycles,
// active-low pads, leading-zero suppression on.
module tb_seg7_mux_driver;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic        LOAD_IN;
    logic [15:0] DIGITS_IN;
    logic [3:0]  DP_IN;
    logic [3:0]  BLANK_IN;
    logic [3:0]  SEG_SELECT_OUT;
    logic [7:0]  HEX_OUT;
    logic        FRAME_DONE_OUT;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic [3:0][7:0] exp_hex;   // pad values for digits 3..0
    } vec_t;

    vec_t vecs [6];

    seg7_mux_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
        .ACTIVE_LOW(1'b1), .LZ_SUPPRESS(1'b1)
    ) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .LOAD_IN(LOAD_IN),
        .DIGITS_IN(DIGITS_IN), .DP_IN(DP_IN), .BLANK_IN(BLANK_IN),
        .SEG_SELECT_OUT(SEG_SELECT_OUT), .HEX_OUT(HEX_OUT),
        .FRAME_DONE_OUT(FRAME_DONE_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Wait for the first active cycle of digit d's slot, then check its segments.
    task automatic wait_sel(input string name, input int d, input logic [7:0] exp_hex);
        logic [3:0] want;
        bit found;
        want  = ~(4'b0001 << d);
        found = 1'b0;
        for (int k = 0; k < 48 && !found; k++) begin
            @(negedge CLK);
            if (SEG_SELECT_OUT === want) found = 1'b1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting select=%h", name, want);
        end else begin
            check(name, {8'h0, HEX_OUT}, {8'h0, exp_hex});
        end
    endtask

    task automatic load(input logic [15:0] dg, input logic [3:0] dp, input logic [3:0] bl);
        LOAD_IN = 1'b1; DIGITS_IN = dg; DP_IN = dp; BLANK_IN = bl;
        @(negedge CLK);
        LOAD_IN = 1'b0;
    endtask

    // Selects must be one-hot or all inactive on every cycle.
    always @(negedge CLK) begin
        if (RESET === 1'b0) begin
            checks++;
            if (!$onehot0(~SEG_SELECT_OUT)) begin
                failures++;
                $display("FAIL onehot actual=%h expected=one-hot-or-idle", SEG_SELECT_OUT);
            end
        end
    end

    function automatic vec_t mk(input logic [15:0] dg, input logic [3:0] dp, input logic [3:0] bl,
                                input logic [7:0] h3, input logic [7:0] h2,
                                input logic [7:0] h1, input logic [7:0] h0);
        vec_t v;
        v.digits = dg; v.dp = dp; v.blank = bl;
        v.exp_hex = {h3, h2, h1, h0};
        return v;
    endfunction

    initial begin
        vecs[0] = mk(16'h1234, 4'h0, 4'h0,    8'hF9, 8'hA4, 8'hB0, 8'h99);
        vecs[1] = mk(16'h0050, 4'h0, 4'h0,    8'hFF, 8'hFF, 8'h92, 8'hC0);
        vecs[2] = mk(16'h1238, 4'b0001, 4'b0010, 8'hF9, 8'hA4, 8'hFF, 8'h00);
        vecs[3] = mk(16'hA0F0, 4'b1000, 4'h0, 8'h08, 8'hC0, 8'h8E, 8'hC0);
        vecs[4] = mk(16'h0000, 4'b0100, 4'h0, 8'hFF, 8'h7F, 8'hFF, 8'hC0);
        vecs[5] = mk(16'h7E9B, 4'h0, 4'h0,    8'hF8, 8'h86, 8'h90, 8'h83);

        RESET = 1'b1; ENABLE = 1'b0; LOAD_IN = 1'b0;
        DIGITS_IN = '0; DP_IN = '0; BLANK_IN = '0;
        repeat (3) @(negedge CLK);
        check("reset_sel", {12'h0, SEG_SELECT_OUT}, 16'h000F);
        check("reset_hex", {8'h0, HEX_OUT}, 16'h00FF);
        check("reset_fd", {15'h0, FRAME_DONE_OUT}, 16'h0);
        RESET = 1'b0;
        @(negedge CLK);

        // Idle load goes straight to the display; then scan from digit 0.
        load(16'h1234, 4'h0, 4'h0);
        ENABLE = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            @(negedge CLK);
            case (c)
                1, 2: check($sformatf("dead_sel_c%0d", c), {12'h0, SEG_SELECT_OUT}, 16'h000F);
                3: begin
                    check("slot0_sel", {12'h0, SEG_SELECT_OUT}, 16'h000E);
                    check("slot0_hex", {8'h0, HEX_OUT}, 16'h0099);
                end
                8:  check("slot0_last_sel", {12'h0, SEG_SELECT_OUT}, 16'h000E);
                9:  check("slot1_dead_sel", {12'h0, SEG_SELECT_OUT}, 16'h000F);
                11: begin
                    check("slot1_sel", {12'h0, SEG_SELECT_OUT}, 16'h000D);
                    check("slot1_hex", {8'h0, HEX_OUT}, 16'h00B0);
                end
                31, 33, 63: check($sformatf("fd_low_c%0d", c), {15'h0, FRAME_DONE_OUT}, 16'h0);
                32, 64:     check($sformatf("fd_high_c%0d", c), {15'h0, FRAME_DONE_OUT}, 16'h1);
                default: ;
            endcase
        end

        // Mid-frame load must not tear the current frame.
        wait_sel("mid_d1_old", 1, 8'hB0);
        load(16'hABCD, 4'h0, 4'h0);
        wait_sel("mid_d2_old", 2, 8'hA4);
        wait_sel("mid_d3_old", 3, 8'hF9);
        wait_sel("mid_d0_new", 0, 8'hA1);
        wait_sel("mid_d1_new", 1, 8'hC6);

        // Pending data, then a load landing on the wrap tick: the latter wins outright.
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                @(negedge CLK);
                if (FRAME_DONE_OUT === 1'b1) seen = 1'b1;
            end
            check("wait_frame_done", {15'h0, seen}, 16'h1);
        end
        load(16'h9999, 4'h0, 4'h0);
        repeat (30) @(negedge CLK);
        load(16'h5678, 4'h0, 4'h0);
        check("coinc_fd_align", {15'h0, FRAME_DONE_OUT}, 16'h1);
        wait_sel("coinc_d0", 0, 8'h80);
        wait_sel("coinc_d3", 3, 8'h92);
        wait_sel("coinc_d0_next", 0, 8'h80);

        // Table: load while idle, then check every digit of one frame.
        for (int v = 0; v < 6; v++) begin
            ENABLE = 1'b0;
            @(negedge CLK);
            check($sformatf("v%0d_idle_sel", v), {12'h0, SEG_SELECT_OUT}, 16'h000F);
            check($sformatf("v%0d_idle_hex", v), {8'h0, HEX_OUT}, 16'h00FF);
            check($sformatf("v%0d_idle_fd", v), {15'h0, FRAME_DONE_OUT}, 16'h0);
            load(vecs[v].digits, vecs[v].dp, vecs[v].blank);
            ENABLE = 1'b1;
            for (int d = 0; d < 4; d++)
                wait_sel($sformatf("v%0d_d%0d", v, d), d, vecs[v].exp_hex[d]);
        end

        // Asynchronous reset in the middle of a slot.
        wait_sel("pre_rst_d2", 2, 8'h86);
        #2 RESET = 1'b1;
        #1;
        check("rst_async_sel", {12'h0, SEG_SELECT_OUT}, 16'h000F);
        check("rst_async_hex", {8'h0, HEX_OUT}, 16'h00FF);
        @(negedge CLK);
        check("rst_hold_sel", {12'h0, SEG_SELECT_OUT}, 16'h000F);
        check("rst_hold_fd", {15'h0, FRAME_DONE_OUT}, 16'h0);
        RESET = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            if (c < 3) check($sformatf("rst_dead_c%0d", c), {12'h0, SEG_SELECT_OUT}, 16'h000F);
            else begin
                check("rst_restart_sel", {12'h0, SEG_SELECT_OUT}, 16'h000E);
                check("rst_cleared_hex", {8'h0, HEX_OUT}, 16'h00C0);
            end
        end
        wait_sel("rst_d1_dark", 1, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_mux_driver.md
SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (>= 2).
REQ-003 SHALL have parameter BLANK_CYCLES, default 4, anti-ghost dead time per slot (< REFRESH_DIV).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1, 1 = segments and selects asserted low.
REQ-005 SHALL have parameter LZ_SUPPRESS, default 0, 1 = blank leading zero digits.
REQ-006 SHALL have port CLK  input  1  system clock; single clock domain.
REQ-007 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port ENABLE  input  1  scan enable.
REQ-009 SHALL have port LOAD_IN  input  1  one-cycle strobe capturing new display data.
REQ-010 SHALL have port DIGITS_IN  input  4*NUM_DIGITS  hex nibbles; nibble 0 = rightmost digit.
REQ-011 SHALL have port DP_IN  input  NUM_DIGITS  decimal point per digit.
REQ-012 SHALL have port BLANK_IN  input  NUM_DIGITS  force digit dark.
REQ-013 SHALL have port SEG_SELECT_OUT  output  NUM_DIGITS  one-hot digit select.
REQ-014 SHALL have port HEX_OUT  output  8  segments; bit0=a .. bit6=g, bit7=dp.
REQ-015 SHALL have port FRAME_DONE_OUT  output  1  one-cycle pulse at end of full scan.

Function
REQ-016 SHALL run prescaler 0..REFRESH_DIV-1 while ENABLE=1; slot tick when prescaler = REFRESH_DIV-1; wraps to 0.
REQ-017 SHALL advance digit index on each tick; index NUM_DIGITS-1 wraps to 0 (frame wrap).
REQ-018 SHALL pulse FRAME_DONE_OUT for exactly one cycle, the cycle after a frame-wrap tick.
REQ-019 SHALL capture DIGITS_IN/DP_IN/BLANK_IN into a pending register and set pending flag on LOAD_IN=1.
REQ-020 SHALL copy pending register to display register on frame wrap when pending flag set, then clear flag; no mid-frame update (tear-free).
REQ-021 SHALL, when LOAD_IN coincides with frame-wrap tick, commit the LOAD_IN data directly to display register and leave pending flag clear.
REQ-022 SHALL, while ENABLE=0, write LOAD_IN data directly to display register.
REQ-023 SHALL, while ENABLE=0, hold prescaler and index, drive all selects and segments inactive, and not pulse FRAME_DONE_OUT.
REQ-024 SHALL drive all selects inactive while prescaler < BLANK_CYCLES in each slot; the indexed select is active for the remaining cycles.
REQ-025 SHALL register SEG_SELECT_OUT and HEX_OUT: outputs reflect index/prescaler with one-cycle latency.
REQ-026 SHALL decode nibbles to standard 7-seg hex 0-F (active-high values: 0=0x3F, 1=0x06, 8=0x7F, A=0x77, F=0x71); DP sets bit7.
REQ-027 SHALL invert all of SEG_SELECT_OUT and HEX_OUT when ACTIVE_LOW=1.
REQ-028 SHALL show a digit dark (segments and dp off, select still scanned) when its BLANK_IN bit is set.
REQ-029 SHALL, with LZ_SUPPRESS=1, darken zero digits above the most-significant non-zero digit; digit 0 never suppressed; DP on a suppressed digit still shown.
REQ-030 SHALL guarantee SEG_SELECT_OUT is one-hot or all-inactive every cycle.

Reset
REQ-031 SHALL on RESET=1 immediately clear prescaler, index, pending flag, pending and display registers, FRAME_DONE_OUT.
REQ-032 SHALL hold SEG_SELECT_OUT and HEX_OUT inactive (all ones when ACTIVE_LOW=1) during reset, including reset asserted mid-slot.
REQ-033 SHALL start scanning from digit 0, prescaler 0, on the first CLK edge after RESET deasserts with ENABLE=1.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1)
REQ-034 SHALL cover: RESET pulse mid-slot -> SEG_SELECT_OUT=4'hF, HEX_OUT=8'hFF in the same cycle; scan restarts at digit 0.
REQ-035 SHALL cover: ENABLE=0, LOAD DIGITS_IN=16'h1234, ENABLE=1 -> slot 0 shows SEG_SELECT_OUT=4'hE, HEX_OUT=~8'h66 after 2 dead cycles; FRAME_DONE_OUT every 32 cycles.
REQ-036 SHALL cover: LOAD 16'hABCD mid-frame -> remaining slots still show old value; new value from next frame digit 0.
REQ-037 SHALL cover: LOAD coincident with frame-wrap tick -> new value displayed at digit 0 of next frame, pending flag 0.
REQ-038 SHALL cover: LZ_SUPPRESS=1, DIGITS_IN=16'h0050 -> digits 3,2 dark, digit 1 shows 5, digit 0 shows 0.
REQ-039 SHALL cover: BLANK_IN=4'b0010, DP_IN=4'b0001 -> digit 1 HEX_OUT=8'hFF, digit 0 bit7=0.
